// File: rtl/lfsr_random_source.sv
// 10-bit maximal-length XNOR LFSR (x^10 + x^7 + 1) that paces the computer
// player. It advances once every TICK_DIV enabled cycles.
module lfsr_random_source #(
    parameter int          TICK_DIV = 4,
    parameter logic [9:0]  SEED     = 10'h000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       load,
    input  logic [9:0] seed_in,
    output logic [9:0] rand_out,
    output logic       tick,
    output logic       wrap,
    output logic       seed_fix
);

    localparam int               DIV_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [9:0]       SEED_SAFE = (SEED == 10'h3FF) ? 10'h000 : SEED;
    localparam logic [9:0]       STEP_LAST = 10'd1022;

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       step_cnt;
    logic [9:0]       lfsr_next;

    // All-ones is the XNOR lock-up state; recover to zero instead of sticking.
    always_comb begin
        lfsr_next = {rand_out[8:0], ~(rand_out[9] ^ rand_out[6])};
        if (rand_out == 10'h3FF) begin
            lfsr_next = 10'h000;
        end
    end

    always_ff @(posedge clk) begin
        tick     <= 1'b0;
        wrap     <= 1'b0;
        seed_fix <= 1'b0;
        if (reset) begin
            rand_out <= SEED_SAFE;
            div_cnt  <= '0;
            step_cnt <= '0;
        end else if (load) begin
            rand_out <= (seed_in == 10'h3FF) ? 10'h000 : seed_in;
            seed_fix <= (seed_in == 10'h3FF);
            div_cnt  <= '0;
            step_cnt <= '0;
        end else if (enable) begin
            if (div_cnt == DIV_LAST) begin
                rand_out <= lfsr_next;
                div_cnt  <= '0;
                tick     <= 1'b1;
                if (step_cnt == STEP_LAST) begin
                    step_cnt <= '0;
                    wrap     <= 1'b1;
                end else begin
                    step_cnt <= step_cnt + 10'd1;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_random_source.sv
// Self-checking bench: two instances (TICK_DIV=1 and TICK_DIV=4) share the
// inputs; a behavioural model feeds a scoreboard and hand tables pin key values.
module tb_lfsr_random_source;

    logic       clk = 1'b0;
    logic       reset = 1'b0, enable = 1'b0, load = 1'b0;
    logic [9:0] seed_in = 10'h000;
    logic [9:0] r1, r4;
    logic       t1, w1, f1, t4, w4, f4;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    lfsr_random_source #(.TICK_DIV(1), .SEED(10'h000)) u1 (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .seed_in(seed_in),
        .rand_out(r1), .tick(t1), .wrap(w1), .seed_fix(f1));

    lfsr_random_source #(.TICK_DIV(4), .SEED(10'h000)) u4 (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .seed_in(seed_in),
        .rand_out(r4), .tick(t4), .wrap(w4), .seed_fix(f4));

    typedef struct {
        logic [9:0] q;
        int         div;
        int         step;
        logic       tick;
        logic       wrap;
        logic       fix;
    } mst_t;

    typedef struct {
        mst_t a;
        mst_t b;
    } pair_t;

    typedef struct {
        logic       rst;
        logic       en;
        logic       ld;
        logic [9:0] sd;
        logic [9:0] r4;
        logic       t4;
        logic       f4;
    } vec_t;

    pair_t exp_q[$];
    mst_t  m1, m4;

    function automatic logic [9:0] ref_next(logic [9:0] q);
        logic fb;
        if (q == 10'h3FF) return 10'h000;
        fb = ~(q[9] ^ q[6]);
        return {q[8:0], fb};
    endfunction

    function automatic mst_t model(mst_t s, int div_max, logic rst, logic en,
                                   logic ld, logic [9:0] sd);
        mst_t n;
        n = s;
        n.tick = 1'b0;
        n.wrap = 1'b0;
        n.fix  = 1'b0;
        if (rst) begin
            n.q = 10'h000; n.div = 0; n.step = 0;
        end else if (ld) begin
            n.q   = (sd == 10'h3FF) ? 10'h000 : sd;
            n.fix = (sd == 10'h3FF);
            n.div = 0; n.step = 0;
        end else if (en) begin
            if (s.div == div_max - 1) begin
                n.q = ref_next(s.q);
                n.div = 0;
                n.tick = 1'b1;
                if (s.step == 1022) begin
                    n.step = 0; n.wrap = 1'b1;
                end else begin
                    n.step = s.step + 1;
                end
            end else begin
                n.div = s.div + 1;
            end
        end
        return n;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    endtask

    // Drive one cycle, push the model's prediction, then pop and compare.
    task automatic cycle(logic r, logic e, logic l, logic [9:0] s);
        pair_t ex;
        reset = r; enable = e; load = l; seed_in = s;
        m1 = model(m1, 1, r, e, l, s);
        m4 = model(m4, 4, r, e, l, s);
        exp_q.push_back('{a: m1, b: m4});
        @(posedge clk);
        #1;
        ex = exp_q.pop_front();
        chk("u1.rand_out", 32'(r1), 32'(ex.a.q));
        chk("u1.tick",     32'(t1), 32'(ex.a.tick));
        chk("u1.wrap",     32'(w1), 32'(ex.a.wrap));
        chk("u1.seed_fix", 32'(f1), 32'(ex.a.fix));
        chk("u4.rand_out", 32'(r4), 32'(ex.b.q));
        chk("u4.tick",     32'(t4), 32'(ex.b.tick));
        chk("u4.wrap",     32'(w4), 32'(ex.b.wrap));
        chk("u4.seed_fix", 32'(f4), 32'(ex.b.fix));
    endtask

    function automatic vec_t mk(logic rst, logic en, logic ld, logic [9:0] sd,
                                logic [9:0] er, logic et, logic ef);
        vec_t v;
        v.rst = rst; v.en = en; v.ld = ld; v.sd = sd;
        v.r4 = er; v.t4 = et; v.f4 = ef;
        return v;
    endfunction

    initial begin
        vec_t       vecs[$];
        logic [9:0] seq1[10];
        bit         seen[1024];
        int         dups;

        m1 = '{q: 10'h000, div: 0, step: 0, tick: 1'b0, wrap: 1'b0, fix: 1'b0};
        m4 = m1;

        // Hand-derived expectations for the TICK_DIV=4 instance.
        vecs.push_back(mk(1, 0, 0, 10'h000, 10'h000, 0, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 0, 10'h000, 10'h000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 10'h000, 10'h001, 1, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 0, 10'h000, 10'h001, 0, 0));
        vecs.push_back(mk(0, 1, 0, 10'h000, 10'h003, 1, 0));
        vecs.push_back(mk(1, 1, 0, 10'h000, 10'h000, 0, 0));
        for (int i = 0; i < 2; i++) vecs.push_back(mk(0, 1, 0, 10'h000, 10'h000, 0, 0));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 0, 10'h000, 10'h000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 10'h000, 10'h000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 10'h000, 10'h001, 1, 0));
        vecs.push_back(mk(0, 0, 1, 10'h3FF, 10'h000, 0, 1));
        vecs.push_back(mk(0, 0, 0, 10'h000, 10'h000, 0, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 0, 10'h000, 10'h000, 0, 0));
        vecs.push_back(mk(0, 1, 1, 10'h155, 10'h155, 0, 0));
        vecs.push_back(mk(0, 1, 0, 10'h000, 10'h155, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].rst, vecs[i].en, vecs[i].ld, vecs[i].sd);
            chk($sformatf("tbl%0d.rand4", i), 32'(r4), 32'(vecs[i].r4));
            chk($sformatf("tbl%0d.tick4", i), 32'(t4), 32'(vecs[i].t4));
            chk($sformatf("tbl%0d.fix4", i),  32'(f4), 32'(vecs[i].f4));
        end

        // Reset in the middle of a sequence, with a partial prescaler count.
        cycle(1, 0, 0, 10'h000);
        for (int i = 0; i < 64 && r4 != 10'h0FE; i++) cycle(0, 1, 0, 10'h000);
        chk("reach_0fe", 32'(r4), 32'h0FE);
        cycle(0, 1, 0, 10'h000);
        cycle(1, 1, 0, 10'h000);
        chk("midrst.rand4", 32'(r4), 32'h000);
        chk("midrst.flags4", 32'({t4, w4, f4}), 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 10'h000);
            chk("midrst.hold4", 32'({r4, t4}), 32'({10'h000, 1'b0}));
        end
        cycle(0, 1, 0, 10'h000);
        chk("midrst.first4", 32'({r4, t4}), 32'({10'h001, 1'b1}));

        // Full period on the TICK_DIV=1 instance.
        seq1[0] = 10'h000; seq1[1] = 10'h001; seq1[2] = 10'h003; seq1[3] = 10'h007;
        seq1[4] = 10'h00F; seq1[5] = 10'h01F; seq1[6] = 10'h03F; seq1[7] = 10'h07F;
        seq1[8] = 10'h0FE; seq1[9] = 10'h1FC;
        cycle(1, 0, 0, 10'h000);
        chk("period.start", 32'(r1), 32'h000);
        foreach (seen[i]) seen[i] = 1'b0;
        seen[0] = 1'b1;
        dups = 0;
        for (int k = 1; k <= 1023; k++) begin
            cycle(0, 1, 0, 10'h000);
            if (k < 10) begin
                chk($sformatf("seq1[%0d]", k), 32'(r1), 32'(seq1[k]));
                chk($sformatf("seq1.tick[%0d]", k), 32'(t1), 32'h1);
            end
            if (k < 1023) begin
                if (seen[r1] || r1 == 10'h3FF) dups++;
                seen[r1] = 1'b1;
            end
        end
        chk("period.distinct", 32'(dups), 32'h0);
        chk("period.return", 32'(r1), 32'h000);
        chk("period.wrap", 32'({w1, t1}), 32'h3);
        cycle(0, 1, 0, 10'h000);
        chk("period.after", 32'({r1, w1}), 32'({10'h001, 1'b0}));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lfsr_random_source.md
Name: lfsr_random_source

Overview:
- 10-bit pseudo-random number source for the computer player.
- Output rand_out drives the A input of the downstream comparator; the player's switch value drives B. The comparator result decides whether the computer "presses" this cycle.
- Advances a maximal-length XNOR LFSR once every TICK_DIV enabled cycles.
- Supports seed loading, lock-up-state protection, an update strobe and a full-period wrap strobe.

Parameters:
- TICK_DIV, 4: enabled clock cycles per LFSR advance; legal range 1..1024.
- SEED, 10'h000: reset value of the LFSR. 10'h3FF is illegal and is replaced by 10'h000.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  advance permission; when low, all state holds.
- load  input  1  load seed_in into the LFSR this cycle.
- seed_in  input  10  seed value used when load=1.
- rand_out  output  10  current LFSR state; feeds comparator A.
- tick  output  1  one-cycle pulse, high in the same cycle a newly advanced rand_out first appears.
- wrap  output  1  one-cycle pulse, high coincident with tick when the sequence has completed 1023 advances since the last reset or load.
- seed_fix  output  1  one-cycle pulse, high the cycle after a load of 10'h3FF was sanitized.

Behaviour:
- Feedback: next = {q[8:0], ~(q[9] ^ q[6])}, which is the XNOR form of x^10+x^7+1.
  - Period is 1023; 10'h3FF is the lock-up state and is never produced.
- Internal prescaler div_cnt runs 0..TICK_DIV-1, width clog2(TICK_DIV) with a minimum of 1 bit.
  - Internal step_cnt runs 0..1022, 10 bits.
- Reset (synchronous, priority 1):
  - rand_out = SEED (sanitized).
  - div_cnt = 0, step_cnt = 0.
  - tick = 0, wrap = 0, seed_fix = 0.
- Load (priority 2, applies when reset=0 and load=1, regardless of enable):
  - rand_out = seed_in, except seed_in = 10'h3FF gives rand_out = 10'h000 and seed_fix = 1 on the next cycle.
  - div_cnt = 0, step_cnt = 0, tick = 0, wrap = 0.
- Advance (priority 3, applies when enable=1 and div_cnt == TICK_DIV-1):
  - rand_out = next, div_cnt = 0, tick = 1.
  - If step_cnt == 1022: step_cnt = 0 and wrap = 1. Otherwise step_cnt increments and wrap = 0.
- Count (enable=1, div_cnt < TICK_DIV-1): div_cnt increments; tick = 0, wrap = 0.
- Hold (enable=0): rand_out, div_cnt and step_cnt are unchanged; tick = 0, wrap = 0.
- seed_fix is 0 in every cycle except the one following a sanitized load.
- With TICK_DIV=1 and enable held high, rand_out changes every cycle and tick stays at 1.
- Latency: the first advance after reset or load occurs TICK_DIV enabled cycles later.
- Guard: if rand_out ever equals 10'h3FF (e.g. a radiation upset), the next update forces 10'h000.
  - The forced update follows the same enable and div_cnt timing as a normal advance.
- Simultaneous events:
  - load together with an advance condition: the load wins and the advance is dropped.
  - reset overrides everything.
  - Deasserting enable mid-count freezes div_cnt, so the partial count is not lost.
- Outputs are registered only; there is no combinational path from inputs to outputs.

Test Plan:
- TICK_DIV=1, SEED=0, enable=1 after reset -> rand_out sequence is 000, 001, 003, 007, 00F, 01F, 03F, 07F, 0FE, 1FC; tick=1 every cycle.
- TICK_DIV=4, enable=1 after reset -> rand_out=000 for 4 cycles, then 001 with tick high exactly 1 cycle; the next change is 4 cycles later (003).
- TICK_DIV=4; drop enable after 2 counted cycles, hold 5 cycles, then re-enable -> rand_out stays 000 with tick=0 while disabled; it advances to 001 after 2 more enabled cycles.
- load=1 with seed_in=3FF -> rand_out=000, seed_fix=1 for exactly one cycle. load with seed_in=155 together with an advance condition -> rand_out=155, tick=0.
- TICK_DIV=1 from reset, run 1023 advances -> all 1023 values are distinct and none is 3FF; rand_out returns to 000 on advance 1023 with wrap=1 coincident with tick. wrap is never high otherwise.
- Assert reset mid-sequence (rand_out=0FE, div_cnt≠0) -> next cycle rand_out=SEED, tick=wrap=seed_fix=0. Counting restarts a full TICK_DIV cycles later.
